// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// SEG_LUT entries are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANKING,
    SHOW
  } scan_state_t;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_OFF = 7'b111_1111;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
// The output register lives in the scan controller.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner: each slot is BLANK dead
// cycles with all anodes off, then DIV-BLANK cycles driving one digit.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       write,
  input  logic [2:0] sel,
  input  logic [3:0] num,
  input  logic [7:0] blank,
  output logic       segA,
  output logic       segB,
  output logic       segC,
  output logic       segD,
  output logic       segE,
  output logic       segF,
  output logic       segG,
  output logic       an0,
  output logic       an1,
  output logic       an2,
  output logic       an3,
  output logic       an4,
  output logic       an5,
  output logic       an6,
  output logic       an7,
  output logic [2:0] cur_idx,
  output logic       frame_done
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - BLANK - 1);

  logic [3:0]    digits [NUM_DIGITS];
  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [7:0]    an_q;
  logic [6:0]    seg_q;
  logic [6:0]    cur_seg;
  logic [7:0]    show_an;

  // NOTE: the digit file is small, so it takes the async reset; a digit
  // that is never written must still display as 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digits[i] <= '0;
    end else if (write) begin
      digits[sel] <= num;
    end
  end

  seg7_hex_decode u_dec (
    .hex (digits[cur_idx]),
    .seg (cur_seg)
  );

  // Anode pattern for the current digit, suppressed by its blank bit.
  assign show_an = ~((8'd1 << cur_idx) & ~blank);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur_idx    <= '0;
      cnt        <= '0;
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      // NOTE: outputs default to off each edge; only the SHOW paths drive them.
      an_q       <= '1;
      seg_q      <= SEG_OFF;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state   <= BLANKING;
            cur_idx <= '0;
            cnt     <= '0;
          end
        end
        BLANKING: begin
          if (!en) begin
            state   <= IDLE;
            cur_idx <= '0;
            cnt     <= '0;
          end else if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= SHOW;
            an_q  <= show_an;
            seg_q <= cur_seg;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (!en) begin
            state   <= IDLE;
            cur_idx <= '0;
            cnt     <= '0;
          end else if (cnt == SHOW_LAST) begin
            cnt        <= '0;
            cur_idx    <= cur_idx + 3'd1;
            state      <= BLANKING;
            frame_done <= (cur_idx == 3'd7);
          end else begin
            cnt   <= cnt + 1'b1;
            an_q  <= show_an;
            seg_q <= cur_seg;
          end
        end
        default: begin
          state   <= IDLE;
          cur_idx <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

  assign {an7, an6, an5, an4, an3, an2, an1, an0} = an_q;
  assign {segG, segF, segE, segD, segC, segB, segA} = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized scoreboard bench for seg7_scan_ctrl (DIV=8, BLANK=2): a
// time-based reference model predicts every cycle, a monitor compares.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic [2:0] idx;
    logic       fd;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       write = 1'b0;
  logic [2:0] sel = '0;
  logic [3:0] num = '0;
  logic [7:0] blank = '0;
  logic       segA, segB, segC, segD, segE, segF, segG;
  logic       an0, an1, an2, an3, an4, an5, an6, an7;
  logic [2:0] cur_idx;
  logic       frame_done;

  int n_checks = 0;
  int n_errs   = 0;

  logic [6:0] lut [16];
  bit   [3:0] m_regs [8];
  bit         m_run = 1'b0;
  int         m_t = 0;
  obs_t       exp_q [$];

  seg7_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .en(en), .write(write), .sel(sel), .num(num),
    .blank(blank),
    .segA(segA), .segB(segB), .segC(segC), .segD(segD), .segE(segE),
    .segF(segF), .segG(segG),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3), .an4(an4), .an5(an5),
    .an6(an6), .an7(an7),
    .cur_idx(cur_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.an  = {an7, an6, an5, an4, an3, an2, an1, an0};
    o.seg = {segG, segF, segE, segD, segC, segB, segA};
    o.idx = cur_idx;
    o.fd  = frame_done;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: the scan is a free-running cycle count t since enable;
  // slot = t/DIV, phase = t%DIV, lit when phase >= BLANK.
  always @(posedge clk) begin
    obs_t e;
    int slot, ph;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end else if (!en) begin
      m_run = 1'b0;
    end else begin
      m_t++;
    end
    e = '{an: 8'hFF, seg: 7'h7F, idx: 3'd0, fd: 1'b0};
    if (m_run) begin
      slot  = (m_t / DIV) % 8;
      ph    = m_t % DIV;
      e.idx = 3'(slot);
      e.fd  = (m_t > 0) && (m_t % (8 * DIV) == 0);
      if (ph >= BLANK) begin
        e.seg = lut[m_regs[slot]];
        if (!blank[slot]) e.an[slot] = 1'b0;
      end
    end
    if (!reset && write) m_regs[sel] = num;
    exp_q.push_back(e);
  end

  // Monitor: compare on the falling edge, away from the launching edge.
  always @(negedge clk) begin
    obs_t a, e;
    a = observe();
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("scan_outputs", 32'(a), 32'(e));
    end
    check("anode_onehot", 32'($countones(~a.an) <= 1), 32'd1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_for_show(input int d, input int limit);
    int n = 0;
    obs_t o;
    o = observe();
    while (!(o.idx == 3'(d) && o.an[d] == 1'b0) && n < limit) begin
      tick();
      o = observe();
      n++;
    end
    check("wait_show_digit", 32'(n < limit), 32'd1);
  endtask

  initial begin
    logic [3:0] init_vals [8];
    obs_t o;
    lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    init_vals = '{4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    repeat (3) tick();
    reset = 1'b0;

    // Load digits with the scan disabled.
    for (int i = 0; i < 8; i++) begin
      write = 1'b1;
      sel   = 3'(i);
      num   = init_vals[i];
      tick();
    end
    write = 1'b0;
    repeat (4) tick();

    // Two full frames of plain scanning.
    en = 1'b1;
    repeat (2 * 8 * DIV) tick();

    // Overwrite digit 3 while it is lit.
    wait_for_show(3, 200);
    write = 1'b1; sel = 3'd3; num = 4'h8;
    tick();
    write = 1'b0;
    repeat (8 * DIV) tick();

    // Blank digit 2 for a frame.
    blank = 8'b0000_0100;
    repeat (8 * DIV) tick();
    blank = 8'b0;

    // Drop enable in the middle of digit 5, then restart.
    wait_for_show(5, 200);
    tick(); tick();
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (3 * DIV) tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      write = ($urandom_range(0, 3) == 0);
      sel   = 3'($urandom);
      num   = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank = 8'($urandom);
      if ($urandom_range(0, 29) == 0) blank = 8'b0;
      en = ($urandom_range(0, 149) != 0);
      tick();
    end
    write = 1'b0;
    blank = 8'b0;
    en    = 1'b1;

    // Asynchronous reset between edges while a digit is lit.
    wait_for_show(4, 200);
    tick();
    #1 reset = 1'b1;
    #1;
    o = observe();
    check("async_rst_an", 32'(o.an), 32'hFF);
    check("async_rst_seg", 32'(o.seg), 32'h7F);
    check("async_rst_idx", 32'(o.idx), 32'd0);
    check("async_rst_fd", 32'(o.fd), 32'd0);
    tick();
    reset = 1'b0;
    repeat (8 * DIV + 4) tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
